// File: rtl/beam_scan_controller.sv
// beam_scan_controller
// Steps the beamformer steering index through every direction, integrates
// |sample| over a dwell window per index, and locks onto the loudest one.
// Optional feature macro: AUTO_RESCAN_EN -- when defined, LOCK holds and a new
// scan is launched automatically after RESCAN_FRAMES frame strobes.
module beam_scan_controller #(
   parameter int NUM_STEPS     = 32,
   parameter int SETTLE_FRAMES = 4,
   parameter int DWELL_FRAMES  = 64,
   parameter int SAMPLE_W      = 8,
   parameter int ACC_W         = 24,
   parameter int RESCAN_FRAMES = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                lr_clk,
   input  logic [SAMPLE_W-1:0] sample,
   output logic [4:0]          delay_select,
   output logic                busy,
   output logic                done,
   output logic [4:0]          best_select,
   output logic [ACC_W-1:0]    best_energy
);

`ifdef AUTO_RESCAN_EN
   localparam bit AUTO_RESCAN_ON = 1'b1;
`else
   localparam bit AUTO_RESCAN_ON = 1'b0;
`endif

   // The frame counter is shared between SETTLE, DWELL and (with auto rescan)
   // LOCK, so it is sized for the longest of the windows it has to count.
   localparam int LOCK_FRAMES = AUTO_RESCAN_ON ? RESCAN_FRAMES : 1;
   localparam int MAX_SD      = (SETTLE_FRAMES > DWELL_FRAMES) ? SETTLE_FRAMES : DWELL_FRAMES;
   localparam int MAX_FR      = (MAX_SD > LOCK_FRAMES) ? MAX_SD : LOCK_FRAMES;
   localparam int CNT_W       = $clog2(MAX_FR + 1);

   localparam logic [CNT_W-1:0] SETTLE_N  = CNT_W'(SETTLE_FRAMES);
   localparam logic [CNT_W-1:0] DWELL_N   = CNT_W'(DWELL_FRAMES);
   localparam logic [4:0]       LAST_STEP = 5'(NUM_STEPS - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_DWELL   = 3'd2,
      ST_COMPARE = 3'd3,
      ST_LOCK    = 3'd4
   } state_t;

   // Unsigned magnitude of a two's complement sample; the most negative value
   // maps onto 2^(SAMPLE_W-1), which still fits in SAMPLE_W unsigned bits.
   function automatic logic [SAMPLE_W-1:0] magnitude(input logic [SAMPLE_W-1:0] s);
      if (s[SAMPLE_W-1]) begin
         magnitude = ~s + {{(SAMPLE_W-1){1'b0}}, 1'b1};
      end else begin
         magnitude = s;
      end
   endfunction

   // Accumulator add that clamps at all-ones instead of wrapping.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [SAMPLE_W-1:0] m);
      logic [ACC_W:0] sum;
      sum = {1'b0, a} + {{(ACC_W+1-SAMPLE_W){1'b0}}, m};
      if (sum[ACC_W]) begin
         sat_add = {ACC_W{1'b1}};
      end else begin
         sat_add = sum[ACC_W-1:0];
      end
   endfunction

   logic              sync0_r, sync1_r, sync2_r, frame_r;

   state_t            state_r, state_s;
   logic [4:0]        step_r, step_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s, cnt_sum_s, frame_inc_s;
   logic [ACC_W-1:0]  acc_r, acc_s;
   logic [4:0]        delay_r, delay_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic [4:0]        best_sel_r, best_sel_s;
   logic [ACC_W-1:0]  best_en_r, best_en_s;
   logic              pending_r, pending_s;
   logic              restart_s;
   logic              take_s;
   logic [4:0]        cmp_sel_s;

   // Bring lr_clk into the clk domain and register a one-cycle rising-edge strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync0_r <= 1'b0;
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         frame_r <= 1'b0;
      end else begin
         sync0_r <= lr_clk;
         sync1_r <= sync0_r;
         sync2_r <= sync1_r;
         frame_r <= sync1_r & ~sync2_r;
      end
   end

   // Scan sequencer: next state, counters, accumulator and registered outputs.
   always_comb begin
      state_s     = state_r;
      step_s      = step_r;
      cnt_s       = cnt_r;
      acc_s       = acc_r;
      delay_s     = delay_r;
      done_s      = 1'b0;
      best_sel_s  = best_sel_r;
      best_en_s   = best_en_r;
      pending_s   = 1'b0;
      restart_s   = 1'b0;
      take_s      = 1'b0;
      cmp_sel_s   = best_sel_r;
      frame_inc_s = {{(CNT_W-1){1'b0}}, frame_r};
      cnt_sum_s   = cnt_r + frame_inc_s;

      case (state_r)
         ST_IDLE: begin
            delay_s = best_sel_r;
            if (start || pending_r) begin
               restart_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_SETTLE: begin
            // A frame seen in the preceding COMPARE cycle is already in cnt_r.
            if (cnt_sum_s >= SETTLE_N) begin
               state_s = ST_DWELL;
               cnt_s   = {CNT_W{1'b0}};
               acc_s   = {ACC_W{1'b0}};
            end else begin
               cnt_s = cnt_sum_s;
            end
         end

         ST_DWELL: begin
            if (frame_r) begin
               acc_s = sat_add(acc_r, magnitude(sample));
               if (cnt_sum_s >= DWELL_N) begin
                  state_s = ST_COMPARE;
                  cnt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_sum_s;
               end
            end else begin
               acc_s = acc_r;
            end
         end

         ST_COMPARE: begin
            // Strict greater-than so that ties keep the earlier index.
            if ((step_r == 5'd0) || (acc_r > best_en_r)) begin
               take_s     = 1'b1;
               best_sel_s = step_r;
               best_en_s  = acc_r;
               cmp_sel_s  = step_r;
            end else begin
               take_s     = 1'b0;
               cmp_sel_s  = best_sel_r;
            end
            if (step_r == LAST_STEP) begin
               state_s = ST_LOCK;
               done_s  = 1'b1;
               delay_s = cmp_sel_s;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = ST_SETTLE;
               step_s  = step_r + 5'd1;
               delay_s = step_r + 5'd1;
               cnt_s   = frame_inc_s;
            end
         end

         ST_LOCK: begin
            delay_s = best_sel_r;
`ifdef AUTO_RESCAN_EN
            if (start) begin
               restart_s = 1'b1;
            end else if (frame_r) begin
               if (cnt_sum_s >= CNT_W'(RESCAN_FRAMES)) begin
                  restart_s = 1'b1;
               end else begin
                  cnt_s = cnt_sum_s;
               end
            end else begin
               state_s = ST_LOCK;
            end
`else
            // A start arriving here is carried into IDLE for the next cycle.
            state_s   = ST_IDLE;
            pending_s = start;
`endif
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      if (restart_s) begin
         state_s   = ST_SETTLE;
         step_s    = 5'd0;
         delay_s   = 5'd0;
         best_en_s = {ACC_W{1'b0}};
         cnt_s     = {CNT_W{1'b0}};
         acc_s     = {ACC_W{1'b0}};
         pending_s = 1'b0;
      end else begin
         pending_s = pending_s;
      end

      busy_s = (state_s == ST_SETTLE) || (state_s == ST_DWELL) || (state_s == ST_COMPARE);
   end

   // Sequencer state and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         step_r     <= 5'd0;
         cnt_r      <= {CNT_W{1'b0}};
         acc_r      <= {ACC_W{1'b0}};
         delay_r    <= 5'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         best_sel_r <= 5'd0;
         best_en_r  <= {ACC_W{1'b0}};
         pending_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         step_r     <= step_s;
         cnt_r      <= cnt_s;
         acc_r      <= acc_s;
         delay_r    <= delay_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         best_sel_r <= best_sel_s;
         best_en_r  <= best_en_s;
         pending_r  <= pending_s;
      end
   end

   assign delay_select = delay_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign best_select  = best_sel_r;
   assign best_energy  = best_en_r;

endmodule
